tdp_ram_ctrl: RTL and testbench
===============================

// Module: tdp_ram_ctrl
// PURPOSE
//  Parametrised single-clock true dual-port RAM. Successor to the fixed 32x8 dual-port RAM.
//  Adds the following over that block:
//   - generic width and depth
//   - selectable read latency
//   - read-during-write mode
//   - write-collision arbitration and flag
//   - post-reset memory clear engine
//  Sits between two independent requesters (A, B) and local storage.
// PARAMETERS
//  DATA_W    8  data width per port
//  ADDR_W    5  address width; DEPTH = 2**ADDR_W words
//  RD_LAT    1  read latency in cycles; legal values 1 or 2
//  RDW_MODE  0  cross-port read of an address written the same cycle: 0 = old data, 1 = new data
//  CLR_ON_RST 1 1 = zero all words after reset release; 0 = no clear, BUSY never asserts
// PORTS
//  CLK     in   1       single clock, rising edge
//  RST     in   1       asynchronous, active-high reset
//  ENA     in   1       port A request valid
//  WENA    in   1       port A write (1) / read (0), qualified by ENA
//  AA      in   ADDR_W  port A address
//  DA      in   DATA_W  port A write data
//  QA      out  DATA_W  port A read data
//  VALIDA  out  1       QA carries a new read result this cycle
//  ENB, WENB, AB, DB, QB, VALIDB   same as port A, for port B
//  BUSY    out  1       clear engine active; requests are ignored
//  COLL    out  1       one-cycle pulse: both ports wrote the same address
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - QA = QB = 0; VALIDA = VALIDB = 0; COLL = 0.
//   - BUSY = CLR_ON_RST. Clear address = 0. Memory array is not reset directly.
//  FSM states: CLEAR, RUN.
//   - Reset enters CLEAR if CLR_ON_RST, else RUN.
//   - CLEAR: writes 0 to clear_addr each cycle, then increments it.
//     After word DEPTH-1 it goes to RUN. That is DEPTH cycles with BUSY = 1.
//   - RUN: stays in RUN until the next reset.
//   - Reset during CLEAR restarts the clear from address 0.
//  While BUSY:
//   - ENA/ENB are ignored. No writes occur.
//   - VALIDx stays 0. QA/QB hold 0.
//  Write (ENx & WENx in RUN):
//   - Memory updates at the clock edge.
//   - VALIDx is not asserted. QX holds its value.
//  Read (ENx & !WENx in RUN):
//   - RD_LAT = 1: QX and VALIDx are registered at the first edge after the request,
//     so they are visible in cycle N+1.
//   - RD_LAT = 2: one extra output register stage, visible in cycle N+2.
//   - VALIDx is high for exactly one cycle per accepted read.
//   - QX holds its last value when VALIDx = 0.
//   - Back-to-back reads on the same port are accepted every cycle (fully pipelined).
//  Same address, same cycle, both ports write:
//   - Port A data is stored; port B data is dropped.
//   - COLL = 1 in the next cycle only.
//  Same address, same cycle, one port writes and the other reads:
//   - Reader gets old data if RDW_MODE = 0, new data if RDW_MODE = 1.
//   - COLL stays 0.
//  Same address, both ports read: both return the stored word. No flag.
//  Address arithmetic: AA/AB use all ADDR_W bits. No out-of-range case exists.
//   The clear counter is ADDR_W+1 bits wide so termination is detected without wrap aliasing.
//  Reset mid-operation: in-flight reads are discarded (VALIDx -> 0). Stored data stays undefined
//   until the clear completes (CLR_ON_RST = 1) or is rewritten.
// STRUCTURE
//  Shared package tdp_ram_pkg:
//   - localparams RDW_OLD = 0, RDW_NEW = 1
//   - FSM state encoding ST_CLEAR, ST_RUN
//  Sub-module tdp_ram_rdpipe (params DATA_W, RD_LAT), one instance per port:
//   - takes raw array read data plus the read-accept strobe
//   - produces QX/VALIDX with the configured latency, reset to 0
//  Top holds: storage array, write-port mux (clear vs. user, A-priority), RDW bypass, FSM, COLL register.
// TESTING
//  1. RST pulse, CLR_ON_RST = 1, DEPTH = 32 -> BUSY high for exactly 32 cycles, then low.
//     Read all 32 addresses -> every QA = 0x00.
//  2. Write A@3 = 0xA5. Next cycle read B@3, RD_LAT = 1 -> QB = 0xA5 with VALIDB = 1 one cycle later.
//     Repeat with RD_LAT = 2 -> result two cycles later.
//  3. Same cycle: A writes 7 = 0x11, B writes 7 = 0x22 -> COLL pulses for 1 cycle.
//     Later read of 7 returns 0x11.
//  4. Addr 9 holds 0x33. A writes 9 = 0x44 while B reads 9 in the same cycle
//     -> QB = 0x33 with RDW_MODE = 0; QB = 0x44 with RDW_MODE = 1.
//  5. Request ENA read during BUSY -> VALIDA stays 0, QA = 0.
//     Assert RST at clear address 10 -> BUSY stays high; clear restarts and lasts 32 more cycles.
//  6. Stream of 32 back-to-back reads on A and B concurrently -> 32 consecutive VALID pulses per port,
//     data matches a reference model in order.

Source files
------------

// File: rtl/tdp_ram_pkg.sv
// Shared types and constants for the true dual-port RAM controller.
// Holds the read-during-write mode encodings and the controller FSM states.
package tdp_ram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/tdp_ram_rdpipe.sv
// Read output pipeline for one RAM port: registers raw read data on an accepted read
// and presents it with a latency of one or two cycles, holding the last value otherwise.
module tdp_ram_rdpipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    logic [DATA_W-1:0] q1;
    logic              v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd;
            if (rd) begin
                q1 <= rd_data;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] q2;
            logic              v2;

            // Second stage only captures on a valid first stage so q holds between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        q2 <= q1;
                    end
                end
            end

            assign q     = q2;
            assign valid = v2;
        end else begin : g_lat1
            assign q     = q1;
            assign valid = v1;
        end
    endgenerate

endmodule

// File: rtl/tdp_ram_ctrl.sv
// Single-clock true dual-port RAM with configurable read latency, read-during-write
// behaviour, A-priority write collision handling and a post-reset clear engine.
module tdp_ram_ctrl
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENA,
    input  logic              WENA,
    input  logic [ADDR_W-1:0] AA,
    input  logic [DATA_W-1:0] DA,
    output logic [DATA_W-1:0] QA,
    output logic              VALIDA,
    input  logic              ENB,
    input  logic              WENB,
    input  logic [ADDR_W-1:0] AB,
    input  logic [DATA_W-1:0] DB,
    output logic [DATA_W-1:0] QB,
    output logic              VALIDB,
    output logic              BUSY,
    output logic              COLL
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   clr_addr;
    logic [ADDR_W:0]   clr_addr_nxt;
    logic              busy;
    logic              wr_a;
    logic              wr_b;
    logic              wr_b_eff;
    logic              rd_a;
    logic              rd_b;
    logic              same_addr;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              coll;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // The counter carries one extra bit; it sets exactly when the last word has been cleared.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            ST_CLEAR: begin
                clr_addr_nxt = clr_addr + 1'b1;
                if (clr_addr_nxt[ADDR_W]) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    assign busy      = (state == ST_CLEAR);
    assign same_addr = (AA == AB);
    assign wr_a      = ENA & WENA & ~busy;
    assign wr_b      = ENB & WENB & ~busy;
    assign rd_a      = ENA & ~WENA & ~busy;
    assign rd_b      = ENB & ~WENB & ~busy;
    // Port A wins a same-address double write; port B's data is dropped.
    assign wr_b_eff  = wr_b & ~(wr_a & same_addr);

    always_ff @(posedge CLK) begin
        if (busy) begin
            mem[clr_addr[ADDR_W-1:0]] <= '0;
        end else begin
            if (wr_a) begin
                mem[AA] <= DA;
            end
            if (wr_b_eff) begin
                mem[AB] <= DB;
            end
        end
    end

    // A reader sees the other port's same-cycle write data only in new-data mode.
    always_comb begin
        rd_data_a = mem[AA];
        rd_data_b = mem[AB];
        if (RDW_MODE == RDW_NEW) begin
            if (wr_b && same_addr) begin
                rd_data_a = DB;
            end
            if (wr_a && same_addr) begin
                rd_data_b = DA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            coll <= 1'b0;
        end else begin
            coll <= wr_a & wr_b & same_addr;
        end
    end

    tdp_ram_rdpipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rdpipe_a (
        .clk     (CLK),
        .rst     (RST),
        .rd      (rd_a),
        .rd_data (rd_data_a),
        .q       (QA),
        .valid   (VALIDA)
    );

    tdp_ram_rdpipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rdpipe_b (
        .clk     (CLK),
        .rst     (RST),
        .rd      (rd_b),
        .rd_data (rd_data_b),
        .q       (QB),
        .valid   (VALIDB)
    );

    assign BUSY = busy;
    assign COLL = coll;

endmodule

// File: tb/tb_tdp_ram_ctrl.sv
// Bench for tdp_ram_ctrl: two instances share stimulus, one with 1-cycle latency and
// old-data read-during-write, the other with 2-cycle latency and new-data read-during-write.
module tb_tdp_ram_ctrl;

    typedef struct {
        logic       ena;
        logic       wena;
        logic [4:0] aa;
        logic [7:0] da;
        logic       enb;
        logic       wenb;
        logic [4:0] ab;
        logic [7:0] db;
        logic       coll;
        logic [7:0] ra0;
        logic [7:0] ra1;
        logic [7:0] rb0;
        logic [7:0] rb1;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       ena, wena, enb, wenb;
    logic [4:0] aa, ab;
    logic [7:0] da, db;
    logic [7:0] qa0, qb0, qa1, qb1;
    logic       va0, vb0, va1, vb1;
    logic       busy0, busy1, coll0, coll1;

    int         checks;
    int         errors;
    logic [7:0] model [32];
    // Expected read results: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
    logic [7:0] exp_q [4][$];
    vec_t       tbl [13];

    tdp_ram_ctrl #(
        .DATA_W(8), .ADDR_W(5), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1)
    ) u_dut0 (
        .CLK(clk), .RST(rst),
        .ENA(ena), .WENA(wena), .AA(aa), .DA(da), .QA(qa0), .VALIDA(va0),
        .ENB(enb), .WENB(wenb), .AB(ab), .DB(db), .QB(qb0), .VALIDB(vb0),
        .BUSY(busy0), .COLL(coll0)
    );

    tdp_ram_ctrl #(
        .DATA_W(8), .ADDR_W(5), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1)
    ) u_dut1 (
        .CLK(clk), .RST(rst),
        .ENA(ena), .WENA(wena), .AA(aa), .DA(da), .QA(qa1), .VALIDA(va1),
        .ENB(enb), .WENB(wenb), .AB(ab), .DB(db), .QB(qb1), .VALIDB(vb1),
        .BUSY(busy1), .COLL(coll1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e_a, input logic w_a, input logic [4:0] a_a,
                                input logic [7:0] d_a, input logic e_b, input logic w_b,
                                input logic [4:0] a_b, input logic [7:0] d_b, input logic c,
                                input logic [7:0] r_a0, input logic [7:0] r_a1,
                                input logic [7:0] r_b0, input logic [7:0] r_b1);
        vec_t v;
        v.ena = e_a;  v.wena = w_a; v.aa = a_a; v.da = d_a;
        v.enb = e_b;  v.wenb = w_b; v.ab = a_b; v.db = d_b;
        v.coll = c;   v.ra0 = r_a0; v.ra1 = r_a1; v.rb0 = r_b0; v.rb1 = r_b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic sb(input int idx, input string nm, input logic v, input logic [7:0] q);
        logic [7:0] e;
        if (v) begin
            checks++;
            if (exp_q[idx].size() == 0) begin
                errors++;
                $display("FAIL %s got=valid q=%0h expected=no read pending", nm, q);
            end else begin
                e = exp_q[idx].pop_front();
                if (q !== e) begin
                    errors++;
                    $display("FAIL %s got=%0h expected=%0h", nm, q, e);
                end
            end
        end
    endtask

    task automatic step(input vec_t v);
        ena = v.ena; wena = v.wena; aa = v.aa; da = v.da;
        enb = v.enb; wenb = v.wenb; ab = v.ab; db = v.db;
        @(posedge clk);
        @(negedge clk);
        sb(0, "rd_dut0_a", va0, qa0);
        sb(1, "rd_dut0_b", vb0, qb0);
        sb(2, "rd_dut1_a", va1, qa1);
        sb(3, "rd_dut1_b", vb1, qb1);
    endtask

    // Queue expected reads from the row, mirror its writes into the model, run it, check COLL.
    task automatic apply(input vec_t v);
        if (v.ena && !v.wena) begin
            exp_q[0].push_back(v.ra0);
            exp_q[2].push_back(v.ra1);
        end
        if (v.enb && !v.wenb) begin
            exp_q[1].push_back(v.rb0);
            exp_q[3].push_back(v.rb1);
        end
        if (v.ena && v.wena) model[v.aa] = v.da;
        if (v.enb && v.wenb && !(v.ena && v.wena && v.aa == v.ab)) model[v.ab] = v.db;
        step(v);
        chk("coll_dut0", {31'd0, coll0}, {31'd0, v.coll});
        chk("coll_dut1", {31'd0, coll1}, {31'd0, v.coll});
    endtask

    task automatic stream();
        vec_t       v;
        logic [4:0] a;
        logic [4:0] b;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            b = 5'(i + 7);
            v = mk(1'b1, 1'b0, a, 8'h00, 1'b1, 1'b0, b, 8'h00, 1'b0,
                   8'h00, 8'h00, 8'h00, 8'h00);
            exp_q[0].push_back(model[a]);
            exp_q[2].push_back(model[a]);
            exp_q[1].push_back(model[b]);
            exp_q[3].push_back(model[b]);
            step(v);
            chk("stream_valid_dut0", {30'd0, va0, vb0}, 32'd3);
            if (i > 0) chk("stream_valid_dut1", {30'd0, va1, vb1}, 32'd3);
        end
        step(mk(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
        chk("stream_tail_dut0", {30'd0, va0, vb0}, 32'd0);
        chk("stream_tail_dut1", {30'd0, va1, vb1}, 32'd3);
        step(mk(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
        chk("stream_end_dut1", {30'd0, va1, vb1}, 32'd0);
    endtask

    initial begin
        vec_t idle;
        vec_t rd_a5;
        int   n;

        checks = 0;
        errors = 0;
        idle  = mk(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        rd_a5 = mk(1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

        //          ena   wena  aa     da     enb   wenb  ab     db     coll  ra0    ra1    rb0    rb1
        tbl[0]  = mk(1'b1, 1'b1, 5'd7,  8'h11, 1'b1, 1'b1, 5'd7,  8'h22, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        tbl[1]  = mk(1'b1, 1'b0, 5'd7,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 8'h11, 8'h11, 8'h00, 8'h00);
        tbl[2]  = mk(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1, 5'd9,  8'h33, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        tbl[3]  = mk(1'b1, 1'b1, 5'd9,  8'h44, 1'b1, 1'b0, 5'd9,  8'h00, 1'b0, 8'h00, 8'h00, 8'h33, 8'h44);
        tbl[4]  = mk(1'b1, 1'b0, 5'd9,  8'h00, 1'b1, 1'b0, 5'd9,  8'h00, 1'b0, 8'h44, 8'h44, 8'h44, 8'h44);
        tbl[5]  = mk(1'b1, 1'b0, 5'd9,  8'h00, 1'b1, 1'b1, 5'd9,  8'h55, 1'b0, 8'h44, 8'h55, 8'h00, 8'h00);
        tbl[6]  = mk(1'b1, 1'b1, 5'd12, 8'h66, 1'b1, 1'b1, 5'd13, 8'h77, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        tbl[7]  = mk(1'b1, 1'b0, 5'd13, 8'h00, 1'b1, 1'b0, 5'd12, 8'h00, 1'b0, 8'h77, 8'h77, 8'h66, 8'h66);
        tbl[8]  = mk(1'b1, 1'b1, 5'd20, 8'h99, 1'b0, 1'b1, 5'd20, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        tbl[9]  = mk(1'b1, 1'b0, 5'd20, 8'h00, 1'b1, 1'b0, 5'd9,  8'h00, 1'b0, 8'h99, 8'h99, 8'h55, 8'h55);
        tbl[10] = mk(1'b0, 1'b0, 5'd20, 8'h00, 1'b1, 1'b0, 5'd7,  8'h00, 1'b0, 8'h00, 8'h00, 8'h11, 8'h11);
        tbl[11] = mk(1'b1, 1'b1, 5'd7,  8'hC3, 1'b1, 1'b1, 5'd7,  8'h3C, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        tbl[12] = mk(1'b1, 1'b0, 5'd7,  8'h00, 1'b1, 1'b0, 5'd7,  8'h00, 1'b0, 8'hC3, 8'hC3, 8'hC3, 8'hC3);

        rst = 1'b1;
        ena = 1'b0; wena = 1'b0; aa = '0; da = '0;
        enb = 1'b0; wenb = 1'b0; ab = '0; db = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy", {30'd0, busy0, busy1}, 32'd3);
        chk("rst_valid", {28'd0, va0, vb0, va1, vb1}, 32'd0);
        chk("rst_coll", {30'd0, coll0, coll1}, 32'd0);
        chk("rst_q", {qa0, qb0, qa1, qb1}, 32'd0);

        // Restart the clear partway through: reset at clear address 10.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(rd_a5);
        chk("busy_at_addr10", {30'd0, busy0, busy1}, 32'd3);
        rst = 1'b1;
        #1;
        chk("busy_in_restart", {30'd0, busy0, busy1}, 32'd3);
        @(negedge clk);
        rst = 1'b0;

        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            chk("busy_read_ignored", {va0, va1, 6'd0, qa0, qa1, 8'd0}, 32'd0);
            n++;
            step(rd_a5);
        end
        chk("busy_cycles", n, 32'd32);
        chk("busy_done", {30'd0, busy0, busy1}, 32'd0);

        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        stream();

        // Write then read back on the other port; latency 1 on dut0, 2 on dut1.
        apply(mk(1'b1, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
        apply(mk(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5));
        chk("lat_dut0_n1", {vb0, 15'd0, qb0, 8'd0}, {1'b1, 15'd0, 8'hA5, 8'd0});
        chk("lat_dut1_n1", {31'd0, vb1}, 32'd0);
        apply(idle);
        chk("lat_dut0_n2", {vb0, 15'd0, qb0, 8'd0}, {1'b0, 15'd0, 8'hA5, 8'd0});
        chk("lat_dut1_n2", {vb1, 15'd0, qb1, 8'd0}, {1'b1, 15'd0, 8'hA5, 8'd0});
        apply(idle);
        chk("lat_dut1_hold", {vb1, 15'd0, qb1, 8'd0}, {1'b0, 15'd0, 8'hA5, 8'd0});

        for (int i = 0; i < 13; i++) apply(tbl[i]);
        apply(idle);
        apply(idle);

        for (int i = 0; i < 16; i++) begin
            apply(mk(1'b1, 1'b1, 5'(2 * i), 8'(i * 29 + 1), 1'b1, 1'b1, 5'(2 * i + 1),
                     8'(~(i * 13)), 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
        end
        stream();

        repeat (3) step(idle);
        for (int k = 0; k < 4; k++) chk("pending_reads", exp_q[k].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
